// File: rtl/decoder_scan_pkg.sv
// Shared types and helpers for the registered select decoder with scan mode.
package decoder_pkg;

    // Controller states; SCAN and DONE are only reachable in scan-enabled builds
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } dec_state_t;

    // Widest decoder this package supports, and the select width that implies
    localparam int MAX_NUM_OUT = 256;
    localparam int MAX_SEL_W   = $clog2(MAX_NUM_OUT);

    // Smallest select width able to address num_out outputs (never below 1)
    function automatic int sel_width(input int num_out);
        return (num_out <= 2) ? 1 : $clog2(num_out);
    endfunction

    // One-hot of idx at full package width; all-zero when idx is not a legal output
    function automatic logic [MAX_NUM_OUT-1:0] onehot(input int unsigned idx,
                                                      input int unsigned num_out);
        logic [MAX_NUM_OUT-1:0] v;
        v = '0;
        if (idx < num_out && idx < MAX_NUM_OUT) begin
            v = {{(MAX_NUM_OUT-1){1'b0}}, 1'b1} << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/decoder_scan_onehot.sv
// Combinational binary-to-one-hot decoder with an in-range flag for
// output counts that are not a power of two.
module decoder_onehot
    import decoder_pkg::*;
#(
    parameter int NUM_OUT = 32,
    parameter int SEL_W   = $clog2(NUM_OUT)
) (
    input  logic [SEL_W-1:0]   idx,
    output logic [NUM_OUT-1:0] onehot_out,
    output logic               in_range
);

    // Decode the index; out-of-range indices yield an all-zero vector
    always_comb begin
        onehot_out = NUM_OUT'(onehot(32'(idx), NUM_OUT));
        in_range   = (32'(idx) < NUM_OUT);
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot select decoder with valid/ready handshake and
// out-of-range detection. Defining DECODER_SCAN_EN adds a scan mode that
// walks the strobe across every output in ascending order; without it the
// block is a plain registered decoder and scan_busy/scan_done stay low.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int NUM_OUT = 32,
    parameter int SEL_W   = $clog2(NUM_OUT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [SEL_W-1:0]   sel,
    input  logic               sel_valid,
    output logic               sel_ready,
    input  logic               scan_start,
    output logic [NUM_OUT-1:0] output_selector,
    output logic               out_valid,
    output logic               sel_err,
    output logic               scan_busy,
    output logic               scan_done
);

    logic [SEL_W-1:0]   dec_idx;
    logic [NUM_OUT-1:0] dec_onehot;
    logic               dec_in_range;
    logic               accept;
    logic               strobe_next;
    logic               err_next;

    // Single decoder shared by direct selects and the scan counter
    decoder_onehot #(
        .NUM_OUT (NUM_OUT),
        .SEL_W   (SEL_W)
    ) u_onehot (
        .idx        (dec_idx),
        .onehot_out (dec_onehot),
        .in_range   (dec_in_range)
    );

`ifdef DECODER_SCAN_EN

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_OUT - 1);

    dec_state_t       state;
    dec_state_t       state_next;
    logic [SEL_W-1:0] cnt;
    logic [SEL_W-1:0] cnt_next;

    // A scan request takes priority over a select presented in the same cycle
    assign sel_ready = (state == IDLE) & en & ~scan_start;
    assign accept    = sel_valid & sel_ready;
    assign scan_busy = (state == SCAN);
    assign scan_done = (state == DONE);

    // Next-state, scan counter and strobe request; scan pauses while en is low
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        dec_idx     = sel;
        strobe_next = 1'b0;
        err_next    = 1'b0;
        case (state)
            IDLE: begin
                if (en && scan_start) begin
                    state_next = SCAN;
                    cnt_next   = '0;
                end else if (accept) begin
                    strobe_next = dec_in_range;
                    err_next    = ~dec_in_range;
                end
            end
            SCAN: begin
                dec_idx = cnt;
                if (en) begin
                    strobe_next = 1'b1;
                    if (cnt == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt + SEL_W'(1);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and counter registers; reset aborts any scan in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

`else

    logic unused_scan_start;

    assign unused_scan_start = scan_start;
    assign sel_ready         = en;
    assign accept            = sel_valid & sel_ready;
    assign scan_busy         = 1'b0;
    assign scan_done         = 1'b0;

    // Direct decode only: accepted selects become a strobe or an error pulse
    always_comb begin
        dec_idx     = sel;
        strobe_next = accept & dec_in_range;
        err_next    = accept & ~dec_in_range;
    end

`endif

    // Output register; the vector is forced to zero whenever no strobe is issued
    always_ff @(posedge clk) begin
        if (reset) begin
            output_selector <= '0;
            out_valid       <= 1'b0;
            sel_err         <= 1'b0;
        end else begin
            output_selector <= strobe_next ? dec_onehot : '0;
            out_valid       <= strobe_next;
            sel_err         <= err_next;
        end
    end

endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan: a 32-output and a 20-output instance
// share one stimulus stream and are compared every cycle against a
// behavioural model. Scan checks are active when DECODER_SCAN_EN is defined.
module tb_decoder_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        sel_valid;
    logic        scan_start;
    logic [4:0]  sel;

    logic [31:0] sel_out_a;
    logic        valid_a, ready_a, err_a, busy_a, done_a;
    logic [19:0] sel_out_b;
    logic        valid_b, ready_b, err_b, busy_b, done_b;

    int checks = 0;
    int errors = 0;

    // Model state per instance: 0 = 32 outputs, 1 = 20 outputs
    int unsigned m_num [2] = '{32, 20};
    bit          m_scan [2];
    bit          m_done [2];
    int unsigned m_idx [2];
    logic [31:0] e_sel [2];
    bit          e_valid [2];
    bit          e_err [2];

    always #5 clk = ~clk;

    decoder_scan #(.NUM_OUT(32)) dut_a (
        .clk             (clk),
        .reset           (reset),
        .en              (en),
        .sel             (sel),
        .sel_valid       (sel_valid),
        .sel_ready       (ready_a),
        .scan_start      (scan_start),
        .output_selector (sel_out_a),
        .out_valid       (valid_a),
        .sel_err         (err_a),
        .scan_busy       (busy_a),
        .scan_done       (done_a)
    );

    decoder_scan #(.NUM_OUT(20), .SEL_W(5)) dut_b (
        .clk             (clk),
        .reset           (reset),
        .en              (en),
        .sel             (sel),
        .sel_valid       (sel_valid),
        .sel_ready       (ready_b),
        .scan_start      (scan_start),
        .output_selector (sel_out_b),
        .out_valid       (valid_b),
        .sel_err         (err_b),
        .scan_busy       (busy_b),
        .scan_done       (done_b)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic v, input logic [4:0] s,
                                 input logic st);
        en         = e;
        sel_valid  = v;
        sel        = s;
        scan_start = st;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Predict what each instance must show after this clock edge
    task automatic model_step(input int k);
        bit take;
        e_sel[k]   = '0;
        e_valid[k] = 1'b0;
        e_err[k]   = 1'b0;
        take       = 1'b0;
        if (reset) begin
            m_scan[k] = 1'b0;
            m_done[k] = 1'b0;
            m_idx[k]  = 0;
        end else begin
`ifdef DECODER_SCAN_EN
            if (m_done[k]) begin
                m_done[k] = 1'b0;
            end else if (m_scan[k]) begin
                if (en) begin
                    e_sel[k]   = 32'd1 << m_idx[k];
                    e_valid[k] = 1'b1;
                    if (m_idx[k] == m_num[k] - 1) begin
                        m_scan[k] = 1'b0;
                        m_done[k] = 1'b1;
                    end else begin
                        m_idx[k] = m_idx[k] + 1;
                    end
                end
            end else if (en && scan_start) begin
                m_scan[k] = 1'b1;
                m_idx[k]  = 0;
            end else begin
                take = en && sel_valid;
            end
`else
            take = en && sel_valid;
`endif
            if (take) begin
                if (sel < m_num[k]) begin
                    e_sel[k]   = 32'd1 << sel;
                    e_valid[k] = 1'b1;
                end else begin
                    e_err[k] = 1'b1;
                end
            end
        end
    endtask

    // Advance the reference model on every rising edge
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
    end

    function automatic bit model_ready(input int k);
`ifdef DECODER_SCAN_EN
        return !m_scan[k] && !m_done[k] && en && !scan_start;
`else
        return en;
`endif
    endfunction

    // Compare both instances against the model away from the active edge
    always @(negedge clk) begin
        checkOutput("sel_a",   sel_out_a, e_sel[0]);
        checkOutput("valid_a", 32'(valid_a), 32'(e_valid[0]));
        checkOutput("err_a",   32'(err_a), 32'(e_err[0]));
        checkOutput("busy_a",  32'(busy_a), 32'(m_scan[0]));
        checkOutput("done_a",  32'(done_a), 32'(m_done[0]));
        checkOutput("ready_a", 32'(ready_a), 32'(model_ready(0)));
        checkOutput("sel_b",   {12'b0, sel_out_b}, e_sel[1]);
        checkOutput("valid_b", 32'(valid_b), 32'(e_valid[1]));
        checkOutput("err_b",   32'(err_b), 32'(e_err[1]));
        checkOutput("busy_b",  32'(busy_b), 32'(m_scan[1]));
        checkOutput("done_b",  32'(done_b), 32'(m_done[1]));
        checkOutput("ready_b", 32'(ready_b), 32'(model_ready(1)));
    end

    // Hard time limit so a stuck run still ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached, %0d errors so far", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  strobes;
        bit  seen;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
        repeat (3) step();

        checkOutput("reset_sel_a",   sel_out_a, 32'h0);
        checkOutput("reset_valid_a", 32'(valid_a), 32'h0);
        checkOutput("reset_busy_a",  32'(busy_a), 32'h0);
        checkOutput("reset_done_a",  32'(done_a), 32'h0);
        reset = 1'b0;

        applyStimulus(1'b1, 1'b1, 5'd0, 1'b0);
        step();
        checkOutput("t1_sel0_a", sel_out_a, 32'h1);
        checkOutput("t1_valid0_a", 32'(valid_a), 32'h1);
        applyStimulus(1'b1, 1'b1, 5'd17, 1'b0);
        step();
        checkOutput("t1_sel17_a", sel_out_a, 32'h20000);
        checkOutput("t1_sel17_b", {12'b0, sel_out_b}, 32'h20000);
        applyStimulus(1'b1, 1'b1, 5'd31, 1'b0);
        step();
        checkOutput("t1_sel31_a", sel_out_a, 32'h80000000);
        checkOutput("t1_err31_b", 32'(err_b), 32'h1);

        applyStimulus(1'b1, 1'b1, 5'd25, 1'b0);
        step();
        checkOutput("t2_err25_b",   32'(err_b), 32'h1);
        checkOutput("t2_valid25_b", 32'(valid_b), 32'h0);
        checkOutput("t2_sel25_b",   {12'b0, sel_out_b}, 32'h0);
        checkOutput("t2_sel25_a",   sel_out_a, 32'h2000000);
        applyStimulus(1'b1, 1'b1, 5'd19, 1'b0);
        step();
        checkOutput("t2_sel19_b", {12'b0, sel_out_b}, 32'h80000);
        checkOutput("t2_err19_b", 32'(err_b), 32'h0);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);
        step();
        checkOutput("t2_idle_valid_a", 32'(valid_a), 32'h0);

`ifdef DECODER_SCAN_EN
        $display("[TB] scan build: exercising scan mode");
        applyStimulus(1'b1, 1'b1, 5'd3, 1'b1);
        #1;
        checkOutput("t5_ready_a", 32'(ready_a), 32'h0);
        step();
        applyStimulus(1'b1, 1'b1, 5'd3, 1'b0);
        checkOutput("t5_busy_a",  32'(busy_a), 32'h1);
        checkOutput("t5_valid_a", 32'(valid_a), 32'h0);
        #1;
        checkOutput("t5_ready_scan_a", 32'(ready_a), 32'h0);

        strobes = 0;
        seen    = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            step();
            if (valid_a) strobes++;
            if (done_a) begin
                seen = 1'b1;
            end else if (valid_a && sel_out_a == 32'h200) begin
                en = 1'b0;
                repeat (3) begin
                    step();
                    checkOutput("t4_pause_valid_a", 32'(valid_a), 32'h0);
                end
                en = 1'b1;
                step();
                checkOutput("t4_resume_a", sel_out_a, 32'h400);
                if (valid_a) strobes++;
            end
        end
        checkOutput("t3_done_seen_a", 32'(seen), 32'h1);
        checkOutput("t3_strobes_a", 32'(strobes), 32'd32);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);
        step();
        checkOutput("t3_ready_after_a", 32'(ready_a), 32'h1);

        applyStimulus(1'b1, 1'b0, 5'd0, 1'b1);
        step();
        scan_start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            step();
            if (sel_out_a == 32'h1000) begin
                seen  = 1'b1;
                reset = 1'b1;
                step();
                reset = 1'b0;
                checkOutput("t6_sel_a",   sel_out_a, 32'h0);
                checkOutput("t6_valid_a", 32'(valid_a), 32'h0);
                checkOutput("t6_busy_a",  32'(busy_a), 32'h0);
                checkOutput("t6_done_a",  32'(done_a), 32'h0);
                repeat (25) begin
                    step();
                    checkOutput("t6_no_done_a", 32'(done_a), 32'h0);
                end
            end
        end
        checkOutput("t6_index12_seen_a", 32'(seen), 32'h1);
`else
        $display("[TB] plain build: scan_start must be ignored");
        applyStimulus(1'b1, 1'b1, 5'd3, 1'b1);
        #1;
        checkOutput("t6_ready_a", 32'(ready_a), 32'h1);
        step();
        checkOutput("t6_sel3_a", sel_out_a, 32'h8);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b1);
        repeat (5) begin
            step();
            checkOutput("t6_busy_a",  32'(busy_a), 32'h0);
            checkOutput("t6_valid_a", 32'(valid_a), 32'h0);
        end
`endif

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            applyStimulus($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 31)), $urandom_range(0, 59) == 0);
            step();
        end
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
